// File: rtl/move_controller.sv
// Player movement controller for a maze game.
// Turns direction buttons into one step request for the external collision detector.
// It latches the checked position the detector returns, then waits out a repeat
// cooldown before it accepts the next step.
// Reaching the exit cell advances the map. The exit of the last map ends the game.
module move_controller #(
  parameter int unsigned REPEAT_TICKS = 12500000,
  parameter logic [4:0]  START_X      = 5'd1,
  parameter logic [4:0]  START_Y      = 5'd8,
  parameter logic [4:0]  EXIT_X       = 5'd14,
  parameter logic [4:0]  EXIT_Y       = 5'd13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_left,
  input  logic       key_down,
  input  logic [4:0] new_x_pos,
  input  logic [4:0] new_y_pos,
  output logic [2:0] move,
  output logic [4:0] current_x_pos,
  output logic [4:0] current_y_pos,
  output logic [1:0] map,
  output logic       level_done,
  output logic       game_won
);

  localparam logic [2:0] MoveNone  = 3'b000;
  localparam logic [2:0] MoveRight = 3'b100;
  localparam logic [2:0] MoveUp    = 3'b001;
  localparam logic [2:0] MoveLeft  = 3'b010;
  localparam logic [2:0] MoveDown  = 3'b011;
  localparam logic [1:0] LastMap   = 2'd3;

  // Final count of the cooldown. The counter starts at 0 on entry, so it spends
  // exactly REPEAT_TICKS cycles in COOLDOWN.
  localparam logic [24:0] CoolLast = 25'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StSettle,
    StCooldown
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  move_q, move_d;
  logic [4:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [1:0]  map_q, map_d;
  logic        level_done_q, level_done_d;
  logic        game_won_q, game_won_d;
  logic [24:0] cnt_q, cnt_d;

  logic [2:0]  key_code;
  logic        any_key;
  logic        at_exit;

  // Direction priority on simultaneous presses: right > up > left > down.
  always_comb begin
    key_code = MoveNone;
    if (key_right) begin
      key_code = MoveRight;
    end else if (key_up) begin
      key_code = MoveUp;
    end else if (key_left) begin
      key_code = MoveLeft;
    end else if (key_down) begin
      key_code = MoveDown;
    end
  end

  assign any_key = key_right | key_up | key_left | key_down;
  assign at_exit = (new_x_pos == EXIT_X) && (new_y_pos == EXIT_Y);

  // Next-state logic. Every output is held in a register, so this block only forms *_d.
  always_comb begin
    state_d      = state_q;
    move_d       = move_q;
    x_d          = x_q;
    y_d          = y_q;
    map_d        = map_q;
    level_done_d = 1'b0;
    game_won_d   = game_won_q;
    cnt_d        = cnt_q;

    case (state_q)
      StIdle: begin
        move_d = MoveNone;
        if (any_key && !game_won_q) begin
          move_d  = key_code;
          state_d = StIssue;
        end
      end

      // The move code is held. Keys are ignored until the step completes.
      StIssue: begin
        state_d = StSettle;
      end

      // The detector answer is stable by now. Latch it, then resolve the exit cell.
      StSettle: begin
        move_d  = MoveNone;
        cnt_d   = '0;
        state_d = StCooldown;
        if (at_exit && (map_q != LastMap)) begin
          map_d        = map_q + 2'd1;
          x_d          = START_X;
          y_d          = START_Y;
          level_done_d = 1'b1;
        end else begin
          x_d = new_x_pos;
          y_d = new_y_pos;
          if (at_exit) begin
            game_won_d = 1'b1;
          end
        end
      end

      StCooldown: begin
        move_d = MoveNone;
        if (cnt_q == CoolLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 25'd1;
        end
      end

      default: begin
        move_d  = MoveNone;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers. Reset overrides everything, including a step in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      move_q       <= MoveNone;
      x_q          <= START_X;
      y_q          <= START_Y;
      map_q        <= 2'd0;
      level_done_q <= 1'b0;
      game_won_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      move_q       <= move_d;
      x_q          <= x_d;
      y_q          <= y_d;
      map_q        <= map_d;
      level_done_q <= level_done_d;
      game_won_q   <= game_won_d;
      cnt_q        <= cnt_d;
    end
  end

  assign move          = move_q;
  assign current_x_pos = x_q;
  assign current_y_pos = y_q;
  assign map           = map_q;
  assign level_done    = level_done_q;
  assign game_won      = game_won_q;

endmodule

// File: tb/tb_move_controller.sv
// Testbench for move_controller, with a short cooldown (REPEAT_TICKS = 4).
// A transaction-level reference model predicts every output on every cycle.
// Directed sections add fixed expectations for the key scenarios. A random section
// follows them.
module tb_move_controller;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       kr, ku, kl, kd;
  logic [4:0] nx, ny;
  logic [2:0] move;
  logic [4:0] cur_x, cur_y;
  logic [1:0] map;
  logic       level_done, game_won;

  int total = 0;
  int bad   = 0;

  // Reference model. Phase 0 means waiting for a key. Phases 1 and 2 are the two
  // cycles when the move code is presented. Phases 3..R+2 are the cooldown.
  int         m_phase;
  logic [2:0] m_dir;
  int         m_x, m_y, m_map;
  bit         m_won, m_ld;

  always #5 clk = ~clk;

  move_controller #(
    .REPEAT_TICKS(R),
    .START_X     (5'd1),
    .START_Y     (5'd8),
    .EXIT_X      (5'd14),
    .EXIT_Y      (5'd13)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_right    (kr),
    .key_up       (ku),
    .key_left     (kl),
    .key_down     (kd),
    .new_x_pos    (nx),
    .new_y_pos    (ny),
    .move         (move),
    .current_x_pos(cur_x),
    .current_y_pos(cur_y),
    .map          (map),
    .level_done   (level_done),
    .game_won     (game_won)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_phase = 0; m_dir = 3'd0; m_x = 1; m_y = 8; m_map = 0; m_won = 0; m_ld = 0;
    end else begin
      m_ld = 0;
      if (m_phase == 0) begin
        if ((kr | ku | kl | kd) && !m_won) begin
          m_dir   = kr ? 3'd4 : ku ? 3'd1 : kl ? 3'd2 : 3'd3;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (nx == 5'd14 && ny == 5'd13) begin
          if (m_map < 3) begin
            m_map++; m_x = 1; m_y = 8; m_ld = 1;
          end else begin
            m_x = 14; m_y = 13; m_won = 1;
          end
        end else begin
          m_x = int'(nx); m_y = int'(ny);
        end
        m_phase = 3;
      end else if (m_phase < R + 2) begin
        m_phase++;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  // One clock: update the model at the edge, then compare every output 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("move", 8'(move), (m_phase == 1 || m_phase == 2) ? 8'(m_dir) : 8'd0);
    check("pos_x", 8'(cur_x), 8'(m_x));
    check("pos_y", 8'(cur_y), 8'(m_y));
    check("map", 8'(map), 8'(m_map));
    check("level_done", 8'(level_done), 8'(m_ld));
    check("game_won", 8'(game_won), 8'(m_won));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int last;
    int starts;
    int nz;

    reset = 1'b1; kr = 0; ku = 0; kl = 0; kd = 0; nx = 5'd1; ny = 5'd8;
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_move", 8'(move), 8'd0);
    check("rst_x", 8'(cur_x), 8'd1);
    check("rst_y", 8'(cur_y), 8'd8);
    check("rst_map", 8'(map), 8'd0);
    check("rst_won", 8'(game_won), 8'd0);

    // Single-cycle tap of down with the detector answering (2,8).
    kd = 1; nx = 5'd2; ny = 5'd8;
    cyc();
    kd = 0;
    check("tap_move_a", 8'(move), 8'd3);
    cyc();
    check("tap_move_b", 8'(move), 8'd3);
    check("tap_x_held", 8'(cur_x), 8'd1);
    cyc();
    check("tap_move_c", 8'(move), 8'd0);
    check("tap_x", 8'(cur_x), 8'd2);
    check("tap_y", 8'(cur_y), 8'd8);
    for (int i = 0; i < 4; i++) cyc();

    // Right and down held together: right wins, and a step starts every R+3 cycles.
    kr = 1; kd = 1; nx = 5'd2; ny = 5'd9;
    last = -1; starts = 0;
    for (int i = 0; i < 21; i++) begin
      cyc();
      if (m_phase == 1) begin
        check("hold_code", 8'(move), 8'd4);
        if (last >= 0) check("hold_period", 8'(i - last), 8'(R + 3));
        last = i;
        starts++;
      end
    end
    check("hold_starts", 8'(starts), 8'd3);
    kr = 0; kd = 0;

    // Blocked up move: the position is unchanged, but the full sequence still runs.
    do_reset();
    ku = 1; nx = 5'd1; ny = 5'd8;
    cyc();
    ku = 0;
    nz = (move != 3'd0) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (move != 3'd0) nz++;
    end
    check("blocked_nz_cycles", 8'(nz), 8'd2);
    check("blocked_x", 8'(cur_x), 8'd1);
    check("blocked_y", 8'(cur_y), 8'd8);
    ku = 1;
    cyc();
    ku = 0;
    check("blocked_next_start", 8'(move), 8'd1);
    for (int i = 0; i < 6; i++) cyc();

    // Four exits in a row: three map advances, then the win on map 3.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      kr = 1; nx = 5'd14; ny = 5'd13;
      cyc();
      kr = 0;
      cyc();
      cyc();
      check("exit_ld", 8'(level_done), (k < 3) ? 8'd1 : 8'd0);
      check("exit_map", 8'(map), (k < 3) ? 8'(k + 1) : 8'd3);
      check("exit_won", 8'(game_won), (k == 3) ? 8'd1 : 8'd0);
      check("exit_x", 8'(cur_x), (k < 3) ? 8'd1 : 8'd14);
      check("exit_y", 8'(cur_y), (k < 3) ? 8'd8 : 8'd13);
      cyc();
      check("exit_ld_pulse", 8'(level_done), 8'd0);
      for (int i = 0; i < 3; i++) cyc();
    end
    kr = 1; ku = 1; kl = 1; kd = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("won_no_move", 8'(move), 8'd0);
    end
    check("won_map", 8'(map), 8'd3);
    kr = 0; ku = 0; kl = 0; kd = 0;

    // Reset during SETTLE discards the move in flight.
    do_reset();
    kl = 1; nx = 5'd9; ny = 5'd9;
    cyc();
    kl = 0;
    cyc();
    check("settle_move", 8'(move), 8'd2);
    reset = 1;
    cyc();
    reset = 0;
    check("rst_settle_x", 8'(cur_x), 8'd1);
    check("rst_settle_y", 8'(cur_y), 8'd8);
    check("rst_settle_move", 8'(move), 8'd0);
    // Reset during COOLDOWN.
    kl = 1;
    cyc();
    kl = 0;
    cyc();
    cyc();
    cyc();
    check("cool_x", 8'(cur_x), 8'd9);
    reset = 1;
    cyc();
    reset = 0;
    check("rst_cool_x", 8'(cur_x), 8'd1);
    check("rst_cool_y", 8'(cur_y), 8'd8);
    check("rst_cool_map", 8'(map), 8'd0);
    // A fresh press must be taken at once, so the cooldown did not survive the reset.
    kd = 1; nx = 5'd2; ny = 5'd8;
    cyc();
    kd = 0;
    check("rst_cool_restart", 8'(move), 8'd3);

    // Random keys, detector answers, exits and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      kr = ($urandom_range(0, 3) == 0);
      ku = ($urandom_range(0, 3) == 0);
      kl = ($urandom_range(0, 3) == 0);
      kd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        nx = 5'd14; ny = 5'd13;
      end else begin
        nx = 5'($urandom_range(0, 31)); ny = 5'($urandom_range(0, 31));
      end
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
